// File: rtl/myo_pwm_driver.sv
// myo_pwm_driver: signed PID effort word -> one H-bridge PWM + direction pair.
// Duty is double-buffered and applied only at period boundaries. A dead-time phase
// separates every direction reversal. Optional feature: define PWM_SLEW_LIMIT_EN to
// limit the duty change per period to SLEW_STEP.
module myo_pwm_driver #(
   parameter int unsigned PERIOD      = 2500,
   parameter int unsigned DEAD_CYCLES = 50,
   parameter int unsigned SLEW_STEP   = 64
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] pid_out,
   input  logic        pid_valid,
   input  logic        enable,
   output logic        pwm,
   output logic        dir,
   output logic        period_start,
   output logic [15:0] duty_active,
   output logic        saturated
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DEAD = 2'd2;

   localparam logic [15:0] PERIOD_W  = 16'(PERIOD);
   localparam logic [15:0] LAST_CNT  = 16'(PERIOD - 1);
   localparam logic [15:0] DEAD_LAST = 16'(DEAD_CYCLES - 1);
   localparam logic [32:0] PERIOD_33 = 33'(PERIOD);

   logic [15:0] cnt_q, cnt_d;
   logic        boundary;
   logic [32:0] mag_abs;
   logic        mag_sat;
   logic [15:0] mag_clamped;
   logic [15:0] shadow_duty_q, shadow_duty_d;
   logic        shadow_dir_q, shadow_dir_d;
   logic        saturated_q, saturated_d;
   logic [15:0] eff_duty;
   logic        eff_dir;
   logic [1:0]  state_q, state_d;
   logic [15:0] dead_cnt_q, dead_cnt_d;
   logic        dir_q, dir_d;
   logic        enter_dead;
   logic [15:0] duty_q, duty_d;
   logic [15:0] duty_target;
   logic        pwm_q, pwm_d;
   logic        period_start_q, period_start_d;

   // Free-running period counter; never gated by enable or state.
   always_comb begin
      boundary = (cnt_q == LAST_CNT);
      cnt_d    = boundary ? 16'd0 : cnt_q + 16'd1;
   end

   // Magnitude in 33 bits so that -2^31 negates without overflow, then clamp.
   always_comb begin
      if (pid_out[31]) begin
         mag_abs = 33'd0 - {1'b1, pid_out};
      end else begin
         mag_abs = {1'b0, pid_out};
      end
      mag_sat     = (mag_abs > PERIOD_33);
      mag_clamped = mag_sat ? PERIOD_W : mag_abs[15:0];
   end

   // Shadow update; a sample arriving in the boundary cycle is seen immediately.
   always_comb begin
      shadow_duty_d = shadow_duty_q;
      shadow_dir_d  = shadow_dir_q;
      saturated_d   = saturated_q;
      if (pid_valid) begin
         shadow_duty_d = mag_clamped;
         shadow_dir_d  = pid_out[31];
         saturated_d   = mag_sat;
      end
      eff_duty = shadow_duty_d;
      eff_dir  = shadow_dir_d;
   end

`ifdef PWM_SLEW_LIMIT_EN
   localparam logic [15:0] STEP_W = 16'(SLEW_STEP);

   // Move the applied duty toward the requested one by at most STEP_W per period.
   always_comb begin
      duty_target = eff_duty;
      if (eff_duty > duty_q) begin
         if ((eff_duty - duty_q) > STEP_W) begin
            duty_target = duty_q + STEP_W;
         end
      end else if ((duty_q - eff_duty) > STEP_W) begin
         duty_target = duty_q - STEP_W;
      end
   end
`else
   logic unused_slew;

   assign duty_target = eff_duty;
   assign unused_slew = ^SLEW_STEP;
`endif

   // Mode FSM: direction only ever changes on the DEAD -> RUN transition.
   always_comb begin
      state_d    = state_q;
      dir_d      = dir_q;
      dead_cnt_d = dead_cnt_q;
      enter_dead = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable && boundary) begin
               if (eff_dir != dir_q) begin
                  enter_dead = 1'b1;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (boundary && (eff_dir != dir_q)) begin
               enter_dead = 1'b1;
            end
         end
         ST_DEAD: begin
            if (!enable) begin
               // Pending reversal stays in the shadow and is re-checked later.
               state_d = ST_IDLE;
            end else if (dead_cnt_q == DEAD_LAST) begin
               dir_d   = eff_dir;
               state_d = ST_RUN;
            end else begin
               dead_cnt_d = dead_cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (enter_dead) begin
         state_d    = ST_DEAD;
         dead_cnt_d = 16'd0;
      end
   end

   // Applied duty changes only at the period boundary.
   always_comb begin
      duty_d = duty_q;
      if (boundary) begin
`ifdef PWM_SLEW_LIMIT_EN
         // Restart the ramp from zero after every reversal.
         duty_d = enter_dead ? 16'd0 : duty_target;
`else
         duty_d = duty_target;
`endif
      end
   end

   // PWM compare and period pulse; enable gates pwm without waiting for the FSM.
   always_comb begin
      pwm_d          = enable && (state_q == ST_RUN) && (cnt_q < duty_q);
      period_start_d = (cnt_q == 16'd0);
   end

   // State registers; reset clears everything so pwm cannot glitch high.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q          <= 16'd0;
         shadow_duty_q  <= 16'd0;
         shadow_dir_q   <= 1'b0;
         saturated_q    <= 1'b0;
         state_q        <= ST_IDLE;
         dead_cnt_q     <= 16'd0;
         dir_q          <= 1'b0;
         duty_q         <= 16'd0;
         pwm_q          <= 1'b0;
         period_start_q <= 1'b0;
      end else begin
         cnt_q          <= cnt_d;
         shadow_duty_q  <= shadow_duty_d;
         shadow_dir_q   <= shadow_dir_d;
         saturated_q    <= saturated_d;
         state_q        <= state_d;
         dead_cnt_q     <= dead_cnt_d;
         dir_q          <= dir_d;
         duty_q         <= duty_d;
         pwm_q          <= pwm_d;
         period_start_q <= period_start_d;
      end
   end

   assign pwm          = pwm_q;
   assign dir          = dir_q;
   assign period_start = period_start_q;
   assign duty_active  = duty_q;
   assign saturated    = saturated_q;

endmodule

// File: tb/tb_myo_pwm_driver.sv
// Directed bench for myo_pwm_driver at default parameters (PERIOD 2500, DEAD 50).
// With PWM_SLEW_LIMIT_EN defined, the slew ramp sequence runs instead.
module tb_myo_pwm_driver;

   logic        clk;
   logic        reset_n;
   logic [31:0] pid_out;
   logic        pid_valid;
   logic        enable;
   logic        pwm;
   logic        dir;
   logic        period_start;
   logic [15:0] duty_active;
   logic        saturated;

   int errors = 0;
   int checks = 0;
   int tb_cnt = 0;
   int highs  = 0;

   myo_pwm_driver dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .pid_out      (pid_out),
      .pid_valid    (pid_valid),
      .enable       (enable),
      .pwm          (pwm),
      .dir          (dir),
      .period_start (period_start),
      .duty_active  (duty_active),
      .saturated    (saturated)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock, then settle; tb_cnt models the DUT period counter.
   task automatic step();
      @(posedge clk);
      #1;
      tb_cnt = (tb_cnt == 2499) ? 0 : tb_cnt + 1;
   endtask

   task automatic goto_cnt(input int c);
      int guard = 0;
      while (tb_cnt != c && guard < 2600) begin
         step();
         guard++;
      end
   endtask

   task automatic next_period();
      step();
      goto_cnt(1);
   endtask

   task automatic sample(input logic [31:0] v);
      pid_out   = v;
      pid_valid = 1'b1;
      step();
      pid_valid = 1'b0;
   endtask

   // Count pwm-high samples across one full period starting at cnt 1.
   task automatic count_high(output int n);
      n = 0;
      for (int i = 0; i < 2500; i++) begin
         if (pwm === 1'b1) n++;
         step();
      end
   endtask

   initial begin
      int guard;
      reset_n   = 1'b0;
      enable    = 1'b0;
      pid_valid = 1'b0;
      pid_out   = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_pwm", 32'(pwm), 32'd0);
      check("rst_dir", 32'(dir), 32'd0);
      check("rst_duty", 32'(duty_active), 32'd0);
      check("rst_sat", 32'(saturated), 32'd0);
      check("rst_pstart", 32'(period_start), 32'd0);

      reset_n = 1'b1;
      enable  = 1'b1;
      guard   = 0;
      step();
      while (period_start !== 1'b1 && guard < 3000) begin
         step();
         guard++;
      end
      check("sync_pstart", 32'(period_start), 32'd1);
      tb_cnt = 1;

`ifdef PWM_SLEW_LIMIT_EN
      goto_cnt(10);
      sample(32'd1000);
      for (int k = 1; k <= 16; k++) begin
         next_period();
         check("slew_duty", 32'(duty_active), (k * 64 > 1000) ? 32'd1000 : 32'(k * 64));
      end
`else
      // 1: +1250 while idle, applied next period
      goto_cnt(10);
      sample(32'd1250);
      check("t1_sat", 32'(saturated), 32'd0);
      check("t1_idle_pwm", 32'(pwm), 32'd0);
      check("t1_duty_pending", 32'(duty_active), 32'd0);
      goto_cnt(1);
      check("t1_duty", 32'(duty_active), 32'd1250);
      check("t1_dir", 32'(dir), 32'd0);
      check("t1_pstart", 32'(period_start), 32'd1);
      count_high(highs);
      check("t1_high_count", 32'(highs), 32'd1250);

      // 2: +100 then -500 -> dead time, reversal
      goto_cnt(100);
      sample(32'd100);
      goto_cnt(1);
      check("t2_duty100", 32'(duty_active), 32'd100);
      goto_cnt(100);
      sample(-32'sd500);
      check("t2_sat", 32'(saturated), 32'd0);
      goto_cnt(1);
      check("t2_duty500", 32'(duty_active), 32'd500);
      check("t2_dead_dir", 32'(dir), 32'd0);
      check("t2_dead_pwm", 32'(pwm), 32'd0);
      goto_cnt(49);
      check("t2_dir49", 32'(dir), 32'd0);
      check("t2_pwm49", 32'(pwm), 32'd0);
      step();
      check("t2_dir50", 32'(dir), 32'd1);
      check("t2_pwm50", 32'(pwm), 32'd0);
      step();
      check("t2_pwm51", 32'(pwm), 32'd1);
      goto_cnt(500);
      check("t2_pwm500", 32'(pwm), 32'd1);
      step();
      check("t2_pwm501", 32'(pwm), 32'd0);

      // 3: most negative input saturates without overflow
      goto_cnt(600);
      sample(32'h8000_0000);
      check("t3_sat", 32'(saturated), 32'd1);
      goto_cnt(1);
      check("t3_duty", 32'(duty_active), 32'd2500);
      check("t3_dir", 32'(dir), 32'd1);
      count_high(highs);
      check("t3_high_count", 32'(highs), 32'd2500);

      // 4: sample in the boundary cycle, then last-one-wins
      goto_cnt(2499);
      sample(32'd300);
      check("t4_duty300", 32'(duty_active), 32'd300);
      check("t4_sat", 32'(saturated), 32'd0);
      goto_cnt(60);
      check("t4_dir", 32'(dir), 32'd0);
      check("t4_pwm60", 32'(pwm), 32'd1);
      goto_cnt(100);
      sample(32'd700);
      goto_cnt(200);
      sample(32'd900);
      goto_cnt(1);
      check("t4_duty900", 32'(duty_active), 32'd900);

      // 5: enable drop mid-period, resume only after boundary
      goto_cnt(100);
      sample(32'd1000);
      goto_cnt(1);
      check("t5_duty", 32'(duty_active), 32'd1000);
      goto_cnt(200);
      check("t5_pwm200", 32'(pwm), 32'd1);
      enable = 1'b0;
      step();
      check("t5_pwm201", 32'(pwm), 32'd0);
      goto_cnt(400);
      enable = 1'b1;
      goto_cnt(500);
      check("t5_pwm500_idle", 32'(pwm), 32'd0);
      goto_cnt(1);
      check("t5_resume", 32'(pwm), 32'd1);
      goto_cnt(1000);
      check("t5_pwm1000", 32'(pwm), 32'd1);
      step();
      check("t5_pwm1001", 32'(pwm), 32'd0);

      // Saturation edge and zero duty
      goto_cnt(1100);
      sample(32'd2500);
      check("sat_2500", 32'(saturated), 32'd0);
      goto_cnt(1200);
      sample(32'd2501);
      check("sat_2501", 32'(saturated), 32'd1);
      goto_cnt(1300);
      sample(32'd0);
      check("sat_0", 32'(saturated), 32'd0);
      goto_cnt(1);
      check("zero_duty", 32'(duty_active), 32'd0);
      count_high(highs);
      check("zero_high_count", 32'(highs), 32'd0);

      // Async reset mid-period clears pwm immediately
      goto_cnt(5);
      sample(32'd1500);
      next_period();
      goto_cnt(300);
      check("pre_rst_pwm", 32'(pwm), 32'd1);
      reset_n = 1'b0;
      #1;
      check("mid_rst_pwm", 32'(pwm), 32'd0);
      check("mid_rst_duty", 32'(duty_active), 32'd0);
      check("mid_rst_sat", 32'(saturated), 32'd0);
      check("mid_rst_pstart", 32'(period_start), 32'd0);
      @(posedge clk);
      #1;
      check("held_rst_pwm", 32'(pwm), 32'd0);
      reset_n = 1'b1;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
